// File: rtl/tfb_norm_pkg.sv
// Shared types and helpers for the TFB residue normalizer.
// Holds the FSM state enum, datapath widths and the shifted-modulus helper.
package tfb_norm_pkg;

    localparam int SUM_W  = 20;
    localparam int RES_W  = 18;
    localparam int QUOT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RED2,
        RED1,
        RED0,
        DONE
    } state_t;

    // MODULUS << k, zero-extended to the internal sum width.
    function automatic logic [SUM_W-1:0] shifted_mod(
        input logic [RES_W-1:0] m,
        input logic [1:0]       k
    );
        logic [SUM_W-1:0] ext;
        ext = {2'b00, m};
        return ext << k;
    endfunction

endpackage

// File: rtl/tfb_cond_sub.sv
// Compare / conditional-subtract step shared by all reduction states.
// Ports: r, m (operands); diff = r - m; take = (r >= m).
module tfb_cond_sub #(
    parameter int W = 20
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] m,
    output logic [W-1:0] diff,
    output logic         take
);

    logic [W:0] d;

    // One subtractor gives both the difference and, via the borrow,
    // the unsigned compare.
    assign d    = {1'b0, r} - {1'b0, m};
    assign diff = d[W-1:0];
    assign take = ~d[W];

endmodule

// File: rtl/tfb_residue_normalizer.sv
// Reduces trunc_sum + lut_sum to its canonical residue mod MODULUS
// by 3-step restoring subtraction (4M, 2M, M), valid/ready on both sides.
// Ports: clk, reset (sync, active high), in_valid/in_ready, trunc_sum[18:0],
// lut_sum[17:0], out_valid/out_ready, residue[17:0], quot[2:0].
// quot and the quotient register exist only with TFB_NORM_QUOT_EN defined.
module tfb_residue_normalizer #(
    parameter logic [17:0] MODULUS = 18'd262139,
    parameter int          SUM_W   = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [18:0] trunc_sum,
    input  logic [17:0] lut_sum,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef TFB_NORM_QUOT_EN
    output logic [2:0]  quot,
`endif
    output logic [17:0] residue
);

    import tfb_norm_pkg::*;

    if (MODULUS < 18'h20000) begin : g_bad_modulus
        $error("MODULUS must be at least 2^17");
    end

    if (SUM_W != 20) begin : g_bad_sum_w
        $error("SUM_W is fixed at 20 by the input widths");
    end

    state_t           state;
    logic [SUM_W-1:0] r_q;
    logic [1:0]       k_sel;
    logic [SUM_W-1:0] m_sel;
    logic [SUM_W-1:0] diff;
    logic             take;
    logic [SUM_W-1:0] r_nxt;

    // Shift amount for the shared subtractor follows the state.
    always_comb begin
        k_sel = 2'd0;
        unique case (state)
            RED2:    k_sel = 2'd2;
            RED1:    k_sel = 2'd1;
            default: k_sel = 2'd0;
        endcase
    end

    assign m_sel = shifted_mod(MODULUS, k_sel);

    tfb_cond_sub #(
        .W (SUM_W)
    ) u_sub (
        .r    (r_q),
        .m    (m_sel),
        .diff (diff),
        .take (take)
    );

    assign r_nxt = take ? diff : r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            r_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            residue   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_q      <= {1'b0, trunc_sum} + {2'b00, lut_sum};
                        in_ready <= 1'b0;
                        state    <= RED2;
                    end
                end
                RED2: begin
                    r_q   <= r_nxt;
                    state <= RED1;
                end
                RED1: begin
                    r_q   <= r_nxt;
                    state <= RED0;
                end
                RED0: begin
                    r_q       <= r_nxt;
                    residue   <= r_nxt[17:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TFB_NORM_QUOT_EN
    logic [QUOT_W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            unique case (state)
                IDLE:    if (in_valid && in_ready) q_q <= '0;
                RED2:    q_q[2] <= take;
                RED1:    q_q[1] <= take;
                RED0:    q_q[0] <= take;
                default: q_q <= q_q;
            endcase
        end
    end

    assign quot = q_q;
`endif

endmodule
